// File: rtl/stack_controller_pkg.sv
// Shared delta encodings and helpers for the J2 stack controller and its users.
package stack_controller_pkg;

  localparam logic [1:0] DELTA_NONE = 2'b00;
  localparam logic [1:0] DELTA_PUSH = 2'b01;
  localparam logic [1:0] DELTA_POP  = 2'b11;
  localparam logic [1:0] DELTA_POP2 = 2'b10;

  // Number of entries a delta code removes from the stack (0, 1 or 2).
  function automatic logic [1:0] pop_amount(input logic [1:0] delta);
    logic [1:0] n;
    case (delta)
      DELTA_POP:  n = 2'd1;
      DELTA_POP2: n = 2'd2;
      default:    n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/stack_controller.sv
// Initiator side of the J2 stack-memory interface: holds TOS, stack pointer,
// entry count and sticky error flags; memory holds every entry below TOS.
module stack_controller
  import stack_controller_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             i_clock,
  input  logic             i_active_low_reset,
  input  logic             i_op_valid,
  input  logic [1:0]       i_delta,
  input  logic [WIDTH-1:0] i_new_top,
  input  logic             i_clear_flags,
  output logic [WIDTH-1:0] o_top,
  output logic [WIDTH-1:0] o_second,
  output logic [DEPTH:0]   o_count,
  output logic             o_overflow,
  output logic             o_underflow,
  output logic [DEPTH-1:0] o_mem_read_address,
  input  logic [WIDTH-1:0] i_mem_read_data,
  output logic             o_mem_write_enable,
  output logic [DEPTH-1:0] o_mem_write_address,
  output logic [WIDTH-1:0] o_mem_write_data
);

  localparam logic [DEPTH:0] C_FULL = {1'b1, {DEPTH{1'b0}}};

  logic [DEPTH-1:0] r_sp;
  logic [WIDTH-1:0] r_top;
  logic [DEPTH:0]   r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_push;
  logic             w_pop;
  logic [DEPTH:0]   w_pop_n;
  logic             w_ovf_set;
  logic             w_unf_set;
  logic [DEPTH:0]   w_count_next;
  logic [DEPTH-1:0] w_sp_next;

  always_comb begin
    w_push       = i_op_valid && (i_delta == DELTA_PUSH);
    w_pop_n      = {{(DEPTH-1){1'b0}}, pop_amount(i_delta)};
    w_pop        = i_op_valid && (w_pop_n != '0);
    w_ovf_set    = w_push && (r_count == C_FULL);
    w_unf_set    = w_pop && (r_count < w_pop_n);
    w_sp_next    = r_sp + {{(DEPTH-2){i_delta[1]}}, i_delta};
    w_count_next = r_count;
    if (w_push && !w_ovf_set) begin
      w_count_next = r_count + 1'b1;
    end else if (w_pop) begin
      w_count_next = w_unf_set ? '0 : (r_count - w_pop_n);
    end
  end

  always_ff @(posedge i_clock or negedge i_active_low_reset) begin
    if (!i_active_low_reset) begin
      r_sp        <= '1;
      r_top       <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (i_op_valid) begin
        r_sp  <= w_sp_next;
        r_top <= i_new_top;
      end
      r_count     <= w_count_next;
      // A new error in the same cycle as a clear leaves the flag set.
      r_overflow  <= w_ovf_set | (r_overflow  & ~i_clear_flags);
      r_underflow <= w_unf_set | (r_underflow & ~i_clear_flags);
    end
  end

  // Write enable is masked during reset so an op in flight cannot commit.
  assign o_mem_write_enable  = w_push && i_active_low_reset;
  assign o_mem_write_address = r_sp + 1'b1;
  assign o_mem_write_data    = r_top;
  assign o_mem_read_address  = r_sp;
  assign o_second            = i_mem_read_data;
  assign o_top               = r_top;
  assign o_count             = r_count;
  assign o_overflow          = r_overflow;
  assign o_underflow         = r_underflow;

endmodule

// File: tb/tb_stack_controller.sv
// Bench for stack_controller: directed scenarios plus random ops against a
// behavioural stack model, with the stack memory emulated here.
module tb_stack_controller;
  import stack_controller_pkg::*;

  localparam int DEPTH = 4;
  localparam int WIDTH = 16;
  localparam int ENTRIES = 16;

  logic             i_clock = 1'b0;
  logic             i_active_low_reset = 1'b0;
  logic             i_op_valid = 1'b0;
  logic [1:0]       i_delta = DELTA_NONE;
  logic [WIDTH-1:0] i_new_top = '0;
  logic             i_clear_flags = 1'b0;
  logic [WIDTH-1:0] o_top, o_second, o_mem_write_data, i_mem_read_data;
  logic [DEPTH:0]   o_count;
  logic             o_overflow, o_underflow, o_mem_write_enable;
  logic [DEPTH-1:0] o_mem_read_address, o_mem_write_address;

  stack_controller #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .i_clock(i_clock), .i_active_low_reset(i_active_low_reset),
    .i_op_valid(i_op_valid), .i_delta(i_delta), .i_new_top(i_new_top),
    .i_clear_flags(i_clear_flags), .o_top(o_top), .o_second(o_second),
    .o_count(o_count), .o_overflow(o_overflow), .o_underflow(o_underflow),
    .o_mem_read_address(o_mem_read_address), .i_mem_read_data(i_mem_read_data),
    .o_mem_write_enable(o_mem_write_enable), .o_mem_write_address(o_mem_write_address),
    .o_mem_write_data(o_mem_write_data)
  );

  always #5 i_clock = ~i_clock;

  // Emulated stack memory: async read, posedge write.
  logic [WIDTH-1:0] mem [ENTRIES];
  assign i_mem_read_data = mem[o_mem_read_address];
  always @(posedge i_clock) if (o_mem_write_enable) mem[o_mem_write_address] <= o_mem_write_data;

  // Reference model
  int               m_sp, m_count;
  logic [WIDTH-1:0] m_top;
  logic             m_ovf, m_unf;
  logic [WIDTH-1:0] m_mem [ENTRIES];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int delta_move(input logic [1:0] d);
    case (d)
      DELTA_PUSH: return 1;
      DELTA_POP:  return -1;
      DELTA_POP2: return -2;
      default:    return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_sp = ENTRIES - 1; m_top = '0; m_count = 0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [1:0] d, input logic [WIDTH-1:0] nt,
                            input logic c);
    int  mv;
    logic ovf_set, unf_set;
    ovf_set = 1'b0; unf_set = 1'b0;
    if (v) begin
      mv = delta_move(d);
      if (mv == 1) begin
        m_mem[(m_sp + 1) % ENTRIES] = m_top;
        if (m_count == ENTRIES) ovf_set = 1'b1;
        else m_count = m_count + 1;
      end else if (mv < 0) begin
        if (m_count < -mv) begin m_count = 0; unf_set = 1'b1; end
        else m_count = m_count + mv;
      end
      m_sp  = (m_sp + mv + ENTRIES) % ENTRIES;
      m_top = nt;
    end
    m_ovf = ovf_set | (m_ovf & ~c);
    m_unf = unf_set | (m_unf & ~c);
  endtask

  task automatic check_state(input string pfx);
    check({pfx, ".top"},    32'(o_top), 32'(m_top));
    check({pfx, ".sp"},     32'(o_mem_read_address), m_sp);
    check({pfx, ".second"}, 32'(o_second), 32'(m_mem[m_sp]));
    check({pfx, ".count"},  32'(o_count), m_count);
    check({pfx, ".ovf"},    32'(o_overflow), 32'(m_ovf));
    check({pfx, ".unf"},    32'(o_underflow), 32'(m_unf));
  endtask

  task automatic do_op(input logic v, input logic [1:0] d, input logic [WIDTH-1:0] nt,
                       input logic c);
    @(negedge i_clock);
    i_op_valid = v; i_delta = d; i_new_top = nt; i_clear_flags = c;
    #1;
    check("op.we", 32'(o_mem_write_enable), 32'(v && d == DELTA_PUSH));
    if (v && d == DELTA_PUSH) begin
      check("op.waddr", 32'(o_mem_write_address), (m_sp + 1) % ENTRIES);
      check("op.wdata", 32'(o_mem_write_data), 32'(m_top));
    end
    @(posedge i_clock);
    model_step(v, d, nt, c);
    #1;
    check_state("op");
  endtask

  task automatic idle();
    @(negedge i_clock);
    i_op_valid = 1'b0; i_delta = DELTA_NONE; i_clear_flags = 1'b0;
  endtask

  // Reset asserted mid-cycle while a push is presented.
  task automatic do_reset(input logic mid_op);
    @(negedge i_clock);
    i_op_valid = mid_op; i_delta = DELTA_PUSH; i_new_top = WIDTH'($urandom);
    i_clear_flags = 1'b0;
    #2 i_active_low_reset = 1'b0;
    #1 check("rst.we", 32'(o_mem_write_enable), 0);
    @(posedge i_clock);
    #1;
    model_reset();
    check_state("rst");
    for (int i = 0; i < ENTRIES; i++) check("rst.mem", 32'(mem[i]), 32'(m_mem[i]));
    @(negedge i_clock);
    i_op_valid = 1'b0; i_delta = DELTA_NONE;
    i_active_low_reset = 1'b1;
  endtask

  initial begin
    int sp_hold, cnt_hold;
    logic [1:0] d;
    for (int i = 0; i < ENTRIES; i++) begin
      mem[i] = WIDTH'(16'hA500 + i);
      m_mem[i] = WIDTH'(16'hA500 + i);
    end
    model_reset();
    #12 i_active_low_reset = 1'b1;
    #1 check_state("init");
    check("init.count0", 32'(o_count), 0);
    check("init.sp15", 32'(o_mem_read_address), 15);

    // Reset while a push is in flight after some activity
    do_op(1'b1, DELTA_PUSH, 16'h1111, 1'b0);
    do_op(1'b1, DELTA_PUSH, 16'h2222, 1'b0);
    do_reset(1'b1);
    check("midrst.top0", 32'(o_top), 0);
    check("midrst.sp15", 32'(o_mem_read_address), 15);

    // Three pushes from reset
    for (int i = 1; i <= 3; i++) do_op(1'b1, DELTA_PUSH, WIDTH'(i), 1'b0);
    check("push3.mem0", 32'(mem[0]), 32'h0000);
    check("push3.mem1", 32'(mem[1]), 32'h0001);
    check("push3.mem2", 32'(mem[2]), 32'h0002);
    check("push3.top",  32'(o_top), 32'h0003);
    check("push3.second", 32'(o_second), 32'h0002);
    check("push3.count", 32'(o_count), 3);

    // Pop two while replacing TOS
    do_op(1'b1, DELTA_POP2, 16'hABCD, 1'b0);
    check("pop2.sp", 32'(o_mem_read_address), 0);
    check("pop2.top", 32'(o_top), 32'hABCD);
    check("pop2.second", 32'(o_second), 32'h0000);
    check("pop2.count", 32'(o_count), 1);
    check("pop2.unf", 32'(o_underflow), 0);
    idle();

    // Overflow on the 17th push
    do_reset(1'b0);
    for (int i = 1; i <= 17; i++) begin
      do_op(1'b1, DELTA_PUSH, WIDTH'(i), 1'b0);
      if (i == 16) check("ovf16.flag", 32'(o_overflow), 0);
    end
    check("ovf17.flag", 32'(o_overflow), 1);
    check("ovf17.count", 32'(o_count), 16);
    check("ovf17.mem0", 32'(mem[0]), 32'd16);
    idle();

    // Underflow and same-cycle clear
    do_reset(1'b0);
    do_op(1'b1, DELTA_POP, 16'h0101, 1'b0);
    check("unf.sp", 32'(o_mem_read_address), 14);
    check("unf.count", 32'(o_count), 0);
    check("unf.flag", 32'(o_underflow), 1);
    do_op(1'b1, DELTA_POP, 16'h0202, 1'b1);
    check("unf.setwins", 32'(o_underflow), 1);
    do_op(1'b0, DELTA_NONE, 16'h0303, 1'b1);
    check("unf.cleared", 32'(o_underflow), 0);

    // Replace only
    sp_hold = int'(o_mem_read_address); cnt_hold = int'(o_count);
    do_op(1'b1, DELTA_NONE, 16'h5555, 1'b0);
    check("repl.top", 32'(o_top), 32'h5555);
    check("repl.sp", 32'(o_mem_read_address), sp_hold);
    check("repl.count", 32'(o_count), cnt_hold);
    idle();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_reset(1'($urandom));
      end else begin
        d = 2'($urandom);
        if (d != DELTA_PUSH && $urandom_range(0, 1) == 0) d = DELTA_PUSH;
        do_op($urandom_range(0, 9) != 0, d, WIDTH'($urandom), $urandom_range(0, 9) == 0);
      end
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
